aes_inv_cipher_iter: RTL and testbench
======================================

// Module: aes_inv_cipher_iter
// PURPOSE
//  AES-128 decryptor (FIPS-197 inverse cipher), iterative: one inverse round per clock.
//  Receive-side counterpart of the unrolled encryption pipeline. Takes 128-bit ciphertext + key, returns plaintext.
//  Key is loaded once and expanded forward to round key 10; later round keys come from the inverse key schedule on the fly.
//  valid/ready handshakes on both sides, so it can sit behind the link RX buffer.
// PARAMETERS
//  NR        10  number of rounds; only 10 (AES-128) supported, elaboration error otherwise
//  CNT_W     4   width of round/expansion counter
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    synchronous, active-low reset
//  key_load   in   1    load key_in; accepted only when key_ready=1
//  key_in     in   128  cipher key, byte 0 at [127:120]
//  key_ready  out  1    1 in IDLE/READY (key may be (re)loaded)
//  in_valid   in   1    ciphertext valid
//  in_ready   out  1    1 only in READY (key expanded, core free)
//  data_in    in   128  ciphertext, byte 0 at [127:120]
//  out_valid  out  1    plaintext valid; held until out_ready
//  out_ready  in   1    downstream accept
//  data_out   out  128  plaintext; stable while out_valid=1
//  busy       out  1    1 in KEY_EXP/ROUND/DONE
// BEHAVIOUR
//  Reset: state=IDLE, key_ready=1, in_ready=0, out_valid=0, busy=0, data_out=0, key-valid flag cleared.
//  Reset mid-operation aborts, discards key and data; in-flight result is never output.
//  FSM: IDLE -key_load-> KEY_EXP; KEY_EXP (10 cycles, cnt 1..10, rk_r=f(rk_{r-1},Rcon[r])) -> READY;
//   READY -in_valid&&in_ready-> ROUND; READY -key_load-> KEY_EXP (new key replaces old);
//   ROUND (cnt 9 downto 0) -cnt==0-> DONE; DONE -out_ready-> READY.
//  key_load and in_valid together in READY: key_load wins, in_ready drops the same cycle? no --
//   in_ready is registered/state-based, so data accepted that cycle uses OLD key; key_load then ignored
//   (key_ready=0 in ROUND). Rule: in READY, data handshake takes priority; key_load only if in_valid=0.
//  Accept cycle: st <= data_in ^ rk10; working key <= rk10.
//  Round r (9..1): st <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk_r)).
//  Final (r=0): st <= InvSubBytes(InvShiftRows(st)) ^ rk0; no InvMixColumns.
//  Inverse key step from rk_r=(a0..a3): b3=a3^a2, b2=a2^a1, b1=a1^a0,
//   b0=a0^SubWord(RotWord(b3))^Rcon[r]; computed in same cycle as round that consumes it.
//  Latency: out_valid rises 11 cycles after the accepting edge; throughput 1 block / 12 cycles min.
//  out_valid stays high and data_out constant until out_ready=1; back-pressure holds DONE indefinitely.
//  Key retained across blocks: no re-expansion between blocks with same key.
//  All arithmetic GF(2^8), poly 0x11B; Rcon wraps only within 1..10; no overflow paths.
// CONFIGURATION
//  AES_DEC_RK_STORE_EN defined: 11x128 round-key register file filled during KEY_EXP;
//   ROUND reads rk[cnt], inverse key schedule logic removed.
//  Undefined (default): on-the-fly inverse schedule, only rk10 + working key stored.
//  Port list, FSM, latency and results identical in both builds; only area/timing differ.
// STRUCTURE
//  Package aes_pkg: sbox/inv_sbox functions, xtime/gmul, inv_mix_column function,
//   Rcon table [1:10], state enum {IDLE,KEY_EXP,READY,ROUND,DONE}.
//  Sub-module aes_inv_round: combinational single inverse round (inputs st, rk, last flag).
//  Top holds FSM, counter, state/key registers, handshakes.
// TESTING
//  Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, 11 cycles.
//  Key 2b7e151628aed2a6abf7158809cf4f3c: after KEY_EXP internal rk10=d014f9a8c9ee2589e13f0cc8b6630ca6;
//   ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
//  Back-to-back: two ciphertexts, same key, no reload -> both correct, second accepted 1 cycle after first out.
//  out_ready low 20 cycles -> out_valid/data_out held stable, in_ready=0 throughout.
//  rst_n low during ROUND cnt=5 -> next cycle out_valid=0, key_ready=1, in_ready=0 until key reloaded.
//  Key reload in READY then decrypt -> result uses new key; run suite with and without AES_DEC_RK_STORE_EN, outputs identical.

Source files
------------

// File: rtl/aes_pkg.sv
// AES GF(2^8) helpers, S-boxes, key-schedule steps and FSM encodings shared by the inverse cipher.
package aes_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_KEY_EXP = 3'd1;
  localparam logic [2:0] S_READY   = 3'd2;
  localparam logic [2:0] S_ROUND   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (product of a^(2^k), k=1..7); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:  r = 8'h01;
      4'd2:  r = 8'h02;
      4'd3:  r = 8'h04;
      4'd4:  r = 8'h08;
      4'd5:  r = 8'h10;
      4'd6:  r = 8'h20;
      4'd7:  r = 8'h40;
      4'd8:  r = 8'h80;
      4'd9:  r = 8'h1b;
      4'd10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return {r, 24'h0};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
            gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
            gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
            gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
  endfunction

  function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ rc;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Recovers rk_{r-1} from rk_r; rc must be Rcon[r].
  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
    {a0, a1, a2, a3} = k;
    b3 = a3 ^ a2;
    b2 = a2 ^ a1;
    b1 = a1 ^ a0;
    b0 = a0 ^ sub_word({b3[23:0], b3[31:24]}) ^ rc;
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round (
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] nxt
);
  import aes_pkg::*;

  logic [127:0] sr, sb, ark, mc;

  // Byte index is 4*col+row with byte 0 in the MSBs; row r rotates right by r columns.
  always_comb begin
    sr = '0;
    sb = '0;
    mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    for (int i = 0; i < 16; i++)
      sb[127 - 8*i -: 8] = inv_sbox(sr[127 - 8*i -: 8]);
    ark = sb ^ rk;
    for (int c = 0; c < 4; c++)
      mc[127 - 32*c -: 32] = inv_mix_column(ark[127 - 32*c -: 32]);
    nxt = last ? ark : mc;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock with valid/ready on both sides.
// AES_DEC_RK_STORE_EN: keep all 11 round keys in registers instead of running the inverse schedule.
module aes_inv_cipher_iter #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  import aes_pkg::*;

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_cipher_iter: only NR=10 is supported");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     st, kx, dout;
  logic [127:0]     kx_next, rk10, rk_cur, rnd_out;

  assign kx_next = fwd_key_step(kx, rcon(4'(cnt)));

`ifdef AES_DEC_RK_STORE_EN
  logic [127:0] rk_mem [0:10];
  assign rk10   = rk_mem[10];
  assign rk_cur = rk_mem[cnt];
`else
  // wk holds rk_{cnt+1}; the round at cnt derives rk_cnt from it in the same cycle.
  logic [127:0] wk;
  assign rk10   = kx;
  assign rk_cur = inv_key_step(wk, rcon(4'(cnt + 1'b1)));
`endif

  aes_inv_round u_round (
    .st   (st),
    .rk   (rk_cur),
    .last (cnt == '0),
    .nxt  (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      st    <= '0;
      kx    <= '0;
      dout  <= '0;
`ifndef AES_DEC_RK_STORE_EN
      wk    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          // A data handshake in READY beats a simultaneous key_load.
          if (state == S_READY && in_valid) begin
            st    <= data_in ^ rk10;
            cnt   <= CNT_W'(NR - 1);
            state <= S_ROUND;
`ifndef AES_DEC_RK_STORE_EN
            wk    <= rk10;
`endif
          end else if (key_load) begin
            kx    <= key_in;
            cnt   <= CNT_W'(1);
            state <= S_KEY_EXP;
`ifdef AES_DEC_RK_STORE_EN
            rk_mem[0] <= key_in;
`endif
          end
        end
        S_KEY_EXP: begin
          kx <= kx_next;
`ifdef AES_DEC_RK_STORE_EN
          rk_mem[cnt] <= kx_next;
`endif
          if (cnt == CNT_W'(NR)) state <= S_READY;
          else                   cnt   <= cnt + 1'b1;
        end
        S_ROUND: begin
          st <= rnd_out;
`ifndef AES_DEC_RK_STORE_EN
          wk <= rk_cur;
`endif
          if (cnt == '0) begin
            dout  <= rnd_out;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: if (out_ready) state <= S_READY;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign key_ready = (state == S_IDLE) || (state == S_READY);
  assign in_ready  = (state == S_READY);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_KEY_EXP) || (state == S_ROUND) || (state == S_DONE);
  assign data_out  = dout;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 and SP800-38A ECB vectors.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_B2 = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic         clk = 1'b0;
  logic         rst_n, key_load, key_ready, in_valid, in_ready;
  logic         out_valid, out_ready, busy;
  logic [127:0] key_in, data_in, data_out;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the core in IDLE/READY; returns at a negedge in READY.
  task automatic load_key(input logic [127:0] k, input string tag);
    int n;
    chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    key_load = 1'b1;
    key_in   = k;
    @(negedge clk);
    key_load = 1'b0;
    chk({tag, "_busy_keyexp"}, {126'(0), busy, key_ready}, {126'(0), 2'b10});
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_keyexp_cycles"}, 128'(n), 128'(10));
  endtask

  // Presents ct in the current READY cycle; optionally raises key_load alongside it
  // and holds out_ready low for `hold` cycles once out_valid appears.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int hold,
                           input logic kl, input logic [127:0] kl_key, input string tag);
    int n;
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    data_in  = ct;
    key_load = kl;
    key_in   = kl_key;
    @(negedge clk);
    in_valid = 1'b0;
    key_load = 1'b0;
    chk({tag, "_accepted"}, {125'(0), in_ready, busy, key_ready}, {125'(0), 3'b010});
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(11));
    chk({tag, "_data"}, data_out, pt);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {data_out[127:2] ^ pt[127:2], out_valid, in_ready}, {126'(0), 2'b10});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_released"}, {126'(0), out_valid, in_ready}, {126'(0), 2'b01});
    chk({tag, "_data_kept"}, data_out, pt);
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data_out", data_out, 128'(0));
    @(negedge clk);
    chk("idle_no_in_ready", 128'(in_ready), 128'(0));

    load_key(KEY_A, "kA");
    run_block(CT_A, PT_A, 0, 1'b0, '0, "decA");
    // key_load together with in_valid: data wins with the old key, new key ignored
    run_block(CT_A, PT_A, 0, 1'b1, KEY_B, "prio");
    run_block(CT_A, PT_A, 20, 1'b0, '0, "backpress");

    // reload in READY, then two blocks back-to-back on the new key
    load_key(KEY_B, "kB");
    run_block(CT_B1, PT_B1, 0, 1'b0, '0, "decB1");
    run_block(CT_B2, PT_B2, 0, 1'b0, '0, "decB2");

    // reset while the round counter sits at 5
    in_valid = 1'b1;
    data_in  = CT_B1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_flags", {124'(0), out_valid, key_ready, in_ready, busy}, {124'(0), 4'b0100});
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {126'(0), out_valid, in_ready}, 128'(0));
    end

    load_key(KEY_A, "kA2");
    run_block(CT_A, PT_A, 0, 1'b0, '0, "decA2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
